// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store misalignment splitter.
package lsu_pkg;

  localparam int unsigned LSU_LANES = 4;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane math for one access: lane mask, split detect, store shift, load merge/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]             off,
  input  logic [1:0]             size,
  input  logic [31:0]            wdata,
  input  logic [63:0]            rdata64,
  input  logic                   uns,
  output logic [2*LSU_LANES-1:0] m8,
  output logic                   split,
  output logic [63:0]            wd64,
  output logic [31:0]            ld_data
);

  logic [2*LSU_LANES-1:0] nmask;
  logic [5:0]             shamt;
  logic [31:0]            r;

  always_comb begin
    nmask   = 8'h0F;
    ld_data = '0;
    shamt   = {1'b0, off, 3'b000};
    r       = 32'(rdata64 >> shamt);
    unique case (size_e'(size))
      LSU_BYTE: begin
        nmask   = 8'h01;
        ld_data = {{24{~uns & r[7]}}, r[7:0]};
      end
      LSU_HALF: begin
        nmask   = 8'h03;
        ld_data = {{16{~uns & r[15]}}, r[15:0]};
      end
      default: begin
        nmask   = 8'h0F;
        ld_data = r;
      end
    endcase
    m8    = nmask << off;
    split = |m8[2*LSU_LANES-1:LSU_LANES];
    wd64  = {32'b0, wdata} << shamt;
  end

endmodule

// File: rtl/lsu_misalign_split.sv
// Load/store splitter: issues one or two word-aligned bus beats per access and merges loads.
module lsu_misalign_split
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_done_o,
  output logic        stall_lsu_o,
  output logic        misalign_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_sel_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  state_e      state;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        req_uns;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        rst_hold;

  logic [7:0]  m8;
  logic        split;
  logic [63:0] wd64;
  logic [31:0] ld_data;
  logic [31:0] base_addr;

  lsu_lane_align u_align (
    .off     (req_addr[1:0]),
    .size    (req_size),
    .wdata   (req_wdata),
    .rdata64 ({hi, lo}),
    .uns     (req_uns),
    .m8      (m8),
    .split   (split),
    .wd64    (wd64),
    .ld_data (ld_data)
  );

  assign base_addr = {req_addr[31:2], 2'b00};

  // rst_hold keeps the first post-reset cycle quiet even if the pipeline still holds a request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_size  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      req_uns   <= 1'b0;
      lo        <= '0;
      hi        <= '0;
      rst_hold  <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu_req_i && !rst_hold) begin
            req_addr  <= lsu_addr_i;
            req_size  <= lsu_size_i;
            req_we    <= lsu_we_i;
            req_wdata <= lsu_wdata_i;
            req_uns   <= lsu_unsigned_i;
            state     <= BEAT0;
          end
        end
        BEAT0: begin
          if (dbus_ack_i) begin
            lo    <= dbus_rdata_i;
            state <= split ? BEAT1 : RESP;
          end
        end
        BEAT1: begin
          if (dbus_ack_i) begin
            hi    <= dbus_rdata_i;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lsu_rdata_o  = '0;
    lsu_done_o   = 1'b0;
    stall_lsu_o  = 1'b0;
    misalign_o   = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_wdata_o = '0;
    dbus_sel_o   = '0;
    unique case (state)
      IDLE: stall_lsu_o = lsu_req_i & ~rst_hold;
      BEAT0: begin
        stall_lsu_o  = 1'b1;
        misalign_o   = split;
        dbus_req_o   = 1'b1;
        dbus_we_o    = req_we;
        dbus_addr_o  = base_addr;
        dbus_sel_o   = m8[3:0];
        dbus_wdata_o = wd64[31:0];
      end
      BEAT1: begin
        stall_lsu_o  = 1'b1;
        misalign_o   = split;
        dbus_req_o   = 1'b1;
        dbus_we_o    = req_we;
        dbus_addr_o  = base_addr + 32'd4;
        dbus_sel_o   = m8[7:4];
        dbus_wdata_o = wd64[63:32];
      end
      RESP: begin
        lsu_done_o  = 1'b1;
        misalign_o  = split;
        lsu_rdata_o = req_we ? '0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_misalign_split.sv
// Directed bench for lsu_misalign_split with a small bus responder and hand-computed expectations.
module tb_lsu_misalign_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_done_o;
  logic        stall_lsu_o;
  logic        misalign_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [3:0]  dbus_sel_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;

  int n_pass  = 0;
  int n_total = 0;

  // observations from the last run_access
  int          o_beats;
  logic [31:0] o_addr [2];
  logic [3:0]  o_sel  [2];
  logic [31:0] o_wd   [2];
  logic        o_we   [2];
  int          o_done;
  logic [31:0] o_rdata;
  logic        o_mis;
  logic        o_stable;
  logic        o_stall;

  always #5 clk = ~clk;

  lsu_misalign_split dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_done_o     (lsu_done_o),
    .stall_lsu_o    (stall_lsu_o),
    .misalign_o     (misalign_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_wdata_o   (dbus_wdata_o),
    .dbus_sel_o     (dbus_sel_o),
    .dbus_ack_i     (dbus_ack_i),
    .dbus_rdata_i   (dbus_rdata_i)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Issues one access (cycle 0 = request cycle), answers beats after d0/d1 wait cycles,
  // scrambles the lsu inputs once accepted, and records what the DUT did.
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int d0, input int d1,
                            input logic [31:0] rd0, input logic [31:0] rd1);
    int beat;
    int waited;
    tick;
    o_beats = 0; o_done = -1; o_rdata = '0; o_mis = 1'b0;
    o_stable = 1'b1; o_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      o_addr[i] = '0; o_sel[i] = '0; o_wd[i] = '0; o_we[i] = 1'b0;
    end
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wdata; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    #1;
    if (stall_lsu_o !== 1'b1) o_stall = 1'b0;
    beat = 0; waited = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick;
      lsu_addr_i     = lsu_addr_i ^ 32'h0000_0F0F;
      lsu_wdata_i    = ~lsu_wdata_i;
      lsu_unsigned_i = ~lsu_unsigned_i;
      dbus_ack_i     = 1'b0;
      dbus_rdata_i   = '0;
      #1;
      if (lsu_done_o === 1'b1) begin
        o_done  = cyc;
        o_rdata = lsu_rdata_o;
        o_mis   = misalign_o;
        if (stall_lsu_o !== 1'b0) o_stall = 1'b0;
        lsu_req_i = 1'b0;
        break;
      end
      if (stall_lsu_o !== 1'b1) o_stall = 1'b0;
      if (dbus_req_o === 1'b1 && beat < 2) begin
        if (waited == 0) begin
          o_addr[beat] = dbus_addr_o; o_sel[beat] = dbus_sel_o;
          o_wd[beat] = dbus_wdata_o; o_we[beat] = dbus_we_o;
          o_beats = beat + 1;
        end else if (dbus_addr_o !== o_addr[beat] || dbus_sel_o !== o_sel[beat] ||
                     dbus_wdata_o !== o_wd[beat] || dbus_we_o !== o_we[beat]) begin
          o_stable = 1'b0;
        end
        if (waited >= ((beat == 0) ? d0 : d1)) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = (beat == 0) ? rd0 : rd1;
          beat++;
          waited = 0;
        end else begin
          waited++;
        end
      end
    end
    if (o_done < 0) $display("FAIL timeout: no done pulse within 30 cycles");
    lsu_req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b10;
    lsu_unsigned_i = 1'b0; lsu_addr_i = 32'h100; lsu_wdata_i = 32'hFFFF_FFFF;
    dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({lsu_rdata_o, lsu_done_o, stall_lsu_o, misalign_o, dbus_req_o, dbus_we_o,
         dbus_addr_o, dbus_wdata_o, dbus_sel_o} !== '0)
      $display("FAIL reset_outputs got req=%b stall=%b done=%b rdata=%h addr=%h sel=%b want all 0",
               dbus_req_o, stall_lsu_o, lsu_done_o, lsu_rdata_o, dbus_addr_o, dbus_sel_o);
    else n_pass++;
    lsu_req_i = 1'b0;
    tick; #1;
    n_total++;
    if (dbus_req_o !== 1'b0 || stall_lsu_o !== 1'b0)
      $display("FAIL reset_no_accept got req=%b stall=%b want 0 0", dbus_req_o, stall_lsu_o);
    else n_pass++;
  endtask

  task automatic test_store_aligned;
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, '0, '0);
    n_total++;
    if (o_beats !== 1 || {o_addr[0], o_sel[0], o_wd[0], o_we[0]} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1})
      $display("FAIL st_aligned_beat got n=%0d addr=%h sel=%b wd=%h we=%b want n=1 addr=00000100 sel=1111 wd=deadbeef we=1",
               o_beats, o_addr[0], o_sel[0], o_wd[0], o_we[0]);
    else n_pass++;
    n_total++;
    if (o_done !== 2 || o_mis !== 1'b0 || o_rdata !== '0 || o_stall !== 1'b1)
      $display("FAIL st_aligned_done got done=%0d mis=%b rdata=%h stall_ok=%b want 2 0 0 1",
               o_done, o_mis, o_rdata, o_stall);
    else n_pass++;
  endtask

  task automatic test_store_split;
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h1122_3344, 0, 0, '0, '0);
    n_total++;
    if (o_beats !== 2 || {o_addr[0], o_sel[0], o_wd[0]} !== {32'h100, 4'b1000, 32'h4400_0000})
      $display("FAIL st_split_beat0 got n=%0d addr=%h sel=%b wd=%h want 2 00000100 1000 44000000",
               o_beats, o_addr[0], o_sel[0], o_wd[0]);
    else n_pass++;
    n_total++;
    if ({o_addr[1], o_sel[1], o_wd[1], o_we[1]} !== {32'h104, 4'b0111, 32'h0011_2233, 1'b1})
      $display("FAIL st_split_beat1 got addr=%h sel=%b wd=%h we=%b want 00000104 0111 00112233 1",
               o_addr[1], o_sel[1], o_wd[1], o_we[1]);
    else n_pass++;
    n_total++;
    if (o_done !== 3 || o_mis !== 1'b1 || o_stall !== 1'b1)
      $display("FAIL st_split_done got done=%0d mis=%b stall_ok=%b want 3 1 1", o_done, o_mis, o_stall);
    else n_pass++;
  endtask

  task automatic test_half_load;
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0207, '0, 0, 0, 32'hAB00_0000, 32'h0000_00CD);
    n_total++;
    if (o_beats !== 2 || {o_addr[0], o_sel[0], o_addr[1], o_sel[1], o_we[0]} !==
        {32'h204, 4'b1000, 32'h208, 4'b0001, 1'b0})
      $display("FAIL ldh_split_beats got n=%0d %h/%b %h/%b we=%b want 2 00000204/1000 00000208/0001 we=0",
               o_beats, o_addr[0], o_sel[0], o_addr[1], o_sel[1], o_we[0]);
    else n_pass++;
    n_total++;
    if (o_rdata !== 32'hFFFF_CDAB || o_done !== 3)
      $display("FAIL ldh_signed got rdata=%h done=%0d want ffffcdab 3", o_rdata, o_done);
    else n_pass++;
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0207, '0, 0, 0, 32'hAB00_0000, 32'h0000_00CD);
    n_total++;
    if (o_rdata !== 32'h0000_CDAB)
      $display("FAIL ldh_unsigned got rdata=%h want 0000cdab", o_rdata);
    else n_pass++;
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0302, '0, 0, 0, 32'h7FFF_0000, '0);
    n_total++;
    if (o_beats !== 1 || o_sel[0] !== 4'b1100 || o_rdata !== 32'h0000_7FFF || o_done !== 2 || o_mis !== 1'b0)
      $display("FAIL ldh_off2 got n=%0d sel=%b rdata=%h done=%0d mis=%b want 1 1100 00007fff 2 0",
               o_beats, o_sel[0], o_rdata, o_done, o_mis);
    else n_pass++;
  endtask

  task automatic test_byte;
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0203, '0, 0, 0, 32'h80AA_BBCC, '0);
    n_total++;
    if (o_beats !== 1 || {o_addr[0], o_sel[0]} !== {32'h200, 4'b1000} || o_rdata !== 32'hFFFF_FF80 || o_done !== 2)
      $display("FAIL ldb_signed got n=%0d addr=%h sel=%b rdata=%h done=%0d want 1 00000200 1000 ffffff80 2",
               o_beats, o_addr[0], o_sel[0], o_rdata, o_done);
    else n_pass++;
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_0203, '0, 0, 0, 32'h80AA_BBCC, '0);
    n_total++;
    if (o_rdata !== 32'h0000_0080)
      $display("FAIL ldb_unsigned got rdata=%h want 00000080", o_rdata);
    else n_pass++;
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_01A3, 32'h0000_00A5, 0, 0, '0, '0);
    n_total++;
    if (o_beats !== 1 || {o_addr[0], o_sel[0], o_wd[0]} !== {32'h1A0, 4'b1000, 32'hA500_0000} || o_mis !== 1'b0)
      $display("FAIL stb_off3 got n=%0d addr=%h sel=%b wd=%h mis=%b want 1 000001a0 1000 a5000000 0",
               o_beats, o_addr[0], o_sel[0], o_wd[0], o_mis);
    else n_pass++;
  endtask

  task automatic test_wrap;
    run_access(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, '0, 0, 0, 32'hBBAA_0000, 32'h0000_DDCC);
    n_total++;
    if (o_beats !== 2 || {o_addr[0], o_sel[0], o_addr[1], o_sel[1]} !==
        {32'hFFFF_FFFC, 4'b1100, 32'h0000_0000, 4'b0011})
      $display("FAIL ldw_wrap_beats got n=%0d %h/%b %h/%b want 2 fffffffc/1100 00000000/0011",
               o_beats, o_addr[0], o_sel[0], o_addr[1], o_sel[1]);
    else n_pass++;
    n_total++;
    if (o_rdata !== 32'hDDCC_BBAA || o_done !== 3)
      $display("FAIL ldw_wrap_data got rdata=%h done=%0d want ddccbbaa 3", o_rdata, o_done);
    else n_pass++;
  endtask

  task automatic test_wait_states;
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0101, '0, 0, 3, 32'h4433_2211, 32'h0000_0055);
    n_total++;
    if (o_beats !== 2 || {o_addr[0], o_sel[0], o_addr[1], o_sel[1]} !==
        {32'h100, 4'b1110, 32'h104, 4'b0001})
      $display("FAIL wait_beats got n=%0d %h/%b %h/%b want 2 00000100/1110 00000104/0001",
               o_beats, o_addr[0], o_sel[0], o_addr[1], o_sel[1]);
    else n_pass++;
    n_total++;
    if (o_stable !== 1'b1 || o_stall !== 1'b1)
      $display("FAIL wait_stable got stable=%b stall_ok=%b want 1 1", o_stable, o_stall);
    else n_pass++;
    n_total++;
    if (o_done !== 6 || o_rdata !== 32'h5544_3322)
      $display("FAIL wait_done got done=%0d rdata=%h want 6 55443322", o_done, o_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_split;
    tick;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_unsigned_i = 1'b0;
    lsu_addr_i = 32'h0000_0103; lsu_wdata_i = '0;
    tick;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    tick;
    #1;
    n_total++;
    if (dbus_req_o !== 1'b1 || dbus_addr_o !== 32'h104)
      $display("FAIL rst_mid_in_beat1 got req=%b addr=%h want 1 00000104", dbus_req_o, dbus_addr_o);
    else n_pass++;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h2222_2222; rst_n = 1'b0;
    tick;
    rst_n = 1'b1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    #1;
    n_total++;
    if ({lsu_rdata_o, lsu_done_o, stall_lsu_o, misalign_o, dbus_req_o, dbus_we_o,
         dbus_addr_o, dbus_wdata_o, dbus_sel_o} !== '0)
      $display("FAIL rst_mid_outputs got req=%b stall=%b done=%b mis=%b addr=%h sel=%b want all 0",
               dbus_req_o, stall_lsu_o, lsu_done_o, misalign_o, dbus_addr_o, dbus_sel_o);
    else n_pass++;
    lsu_req_i = 1'b0;
    tick; #1;
    n_total++;
    if (lsu_done_o !== 1'b0 || dbus_req_o !== 1'b0 || stall_lsu_o !== 1'b0)
      $display("FAIL rst_mid_no_done got done=%b req=%b stall=%b want 0 0 0",
               lsu_done_o, dbus_req_o, stall_lsu_o);
    else n_pass++;
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, '0, 0, 0, 32'h1234_5678, '0);
    n_total++;
    if (o_beats !== 1 || o_addr[0] !== 32'h100 || o_done !== 2 || o_rdata !== 32'h1234_5678)
      $display("FAIL rst_mid_recover got n=%0d addr=%h done=%0d rdata=%h want 1 00000100 2 12345678",
               o_beats, o_addr[0], o_done, o_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_aligned();
    test_store_split();
    test_half_load();
    test_byte();
    test_wrap();
    test_wait_states();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_misalign_split.md
# lsu_misalign_split

Load/store-side counterpart of the fetch-side instruction realigner. It sits between the memory stage and the data bus. It accepts one load/store per request and, when the access crosses a 32-bit word boundary, splits it into two word-aligned bus beats with byte-lane selects. For loads, it merges the two returned words back into one sign- or zero-extended result. The pipeline is stalled while the access is in flight.

## Interface
Parameters:
- none; XLEN fixed at 32, bus word 32 bits, 4 byte lanes.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- lsu_req_i  in  1  memory-stage access valid; held high by the pipeline while stall_lsu_o is high.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- lsu_unsigned_i  in  1  load zero-extend (LBU/LHU).
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, right-justified.
- lsu_rdata_o  out  32  extended load result; valid when lsu_done_o is high.
- lsu_done_o  out  1  one-cycle completion pulse.
- stall_lsu_o  out  1  freeze pipeline.
- misalign_o  out  1  current access is split.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  32  word-aligned address; bits [1:0] are always 00.
- dbus_wdata_o  out  32  lane-positioned write data.
- dbus_sel_o  out  4  byte-lane enables.
- dbus_ack_i  in  1  beat complete; dbus_rdata_i is valid in the same cycle.
- dbus_rdata_i  in  32  read data.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - When lsu_req_i is high, latch addr, size, we, wdata and unsigned into request registers.
  - Go to BEAT0.
  - stall_lsu_o = lsu_req_i.
- Lane math, all from the latched request:
  - o = addr[1:0]; n = 1, 2 or 4 bytes.
  - m8 = ((1<<n)-1) << o, 8 bits wide.
  - split = |m8[7:4].
  - wd64 = {32'b0, wdata} << 8·o.
- BEAT0:
  - Bus outputs: dbus_req_o = 1, addr = {addr[31:2], 2'b00}, sel = m8[3:0], wdata = wd64[31:0].
  - On ack: capture rdata into lo; go to BEAT1 if split, else RESP.
- BEAT1:
  - Bus outputs: addr = BEAT0 address + 4, modulo 2^32 (wraps to 0), sel = m8[7:4], wdata = wd64[63:32].
  - On ack: capture rdata into hi; go to RESP.
- RESP:
  - lsu_done_o = 1, stall_lsu_o = 0.
  - Load result: r = ({hi, lo} >> 8·o)[31:0], truncated to n bytes, then sign-extended, or zero-extended if unsigned.
  - Stores drive lsu_rdata_o = 0.
  - Always returns to IDLE; a new request is accepted no earlier than the following cycle.
- Byte accesses never split. Half accesses split only at o = 3. Word accesses split at o ≠ 0.
- misalign_o = split in BEAT0, BEAT1 and RESP; 0 otherwise.
- Input changes after acceptance are ignored until RESP.
- dbus_we_o equals the latched we in BEAT0 and BEAT1; it is 0 otherwise.
- Any bus output not named for a state is 0.

## Timing
- Reset (rst_n low at posedge):
  - State → IDLE; request, lo and hi registers → 0.
  - All outputs are 0 in the following cycle, including dbus_req_o, stall_lsu_o, lsu_done_o and lsu_rdata_o.
  - This applies mid-beat: no done pulse is produced and a pending ack is ignored.
- Bus outputs decode from registered state only; they have no combinational path from lsu_* inputs.
- Beat stability: while dbus_req_o is high without ack, addr, sel, we and wdata hold steady.
- Between beats, dbus_req_o stays high; addr and sel change in the cycle after the BEAT0 ack.
- Latency, request at cycle T, zero-wait bus:
  - aligned: BEAT0 at T+1, done at T+2.
  - split: BEAT1 at T+2, done at T+3.
  - Each bus wait cycle adds 1.
- stall_lsu_o is high from T through the last beat, and low in RESP.

## Structure
- lsu_pkg holds:
  - size_e (LSU_BYTE, LSU_HALF, LSU_WORD);
  - state enum (IDLE, BEAT0, BEAT1, RESP);
  - lane-count constant, 4.
- One combinational sub-module, lsu_lane_align, computes:
  - inputs: o, size, wdata, {hi, lo}, unsigned;
  - outputs: m8, split, wd64, extended load result.
- lsu_misalign_split holds the FSM and the registers.

## Test plan
- Aligned word store, addr 0x100, data 0xDEADBEEF, ack at T+1:
  - one beat: addr 0x100, sel 1111, wdata 0xDEADBEEF;
  - done at T+2, misalign_o = 0.
- Word store, addr 0x103, data 0x11223344:
  - beat 0x100, sel 1000, wdata 0x44000000;
  - beat 0x104, sel 0111, wdata 0x00112233;
  - done at T+3.
- Signed half load, addr 0x207:
  - beat 0x204, sel 1000, returns 0xAB000000;
  - beat 0x208, sel 0001, returns 0x000000CD;
  - lsu_rdata_o = 0xFFFFCDAB; with unsigned set, 0x0000CDAB.
- Word load, addr 0xFFFFFFFE:
  - beats at 0xFFFFFFFC (sel 1100) then 0x00000000 (sel 0011).
- Wait states:
  - ack delayed 3 cycles on BEAT1 while lsu_addr_i is toggled;
  - bus outputs stay stable, stall_lsu_o stays high, done at T+6.
- Reset mid-split:
  - rst_n low during BEAT1, with ack asserted in the same cycle;
  - next cycle, all outputs are 0 and no done pulse occurs;
  - a following aligned request completes normally.
